// File: rtl/complex_alu_mc.sv
// complex_alu_mc: multi-cycle complex execution unit for the complex-issue lane.
// Multiplies through a MUL_STAGES-deep pipeline. Divides with an iterative
// radix-2 restoring divider on operand magnitudes.
// Optional build macro COMPLEX_ALU_EARLY_OUT_EN: the divider skips the leading
// zero bits of |A|. Divide-by-zero and A == 0 then finish in two cycles.
// Opcode encoding: 0 MULT_L, 1 MULT_H, 2 MULTU_L, 3 MULTU_H, 4 DIV_L, 5 DIV_H,
// 6 DIVU_L, 7 DIVU_H, 8 SYSCALL. All other codes are undefined.

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 4
`endif

module complex_alu_mc #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 3,
  parameter int TAG_W      = 7
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [`SIZE_OPCODE_I-1:0] opcode_i,
  input  logic [DATA_W-1:0]         data1_i,
  input  logic [DATA_W-1:0]         data2_i,
  input  logic [TAG_W-1:0]          tag_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         result_o,
  output logic [5:0]                flags_o,
  output logic [TAG_W-1:0]          tag_o
);

  localparam int OPW  = `SIZE_OPCODE_I;
  localparam int CW   = $clog2(DATA_W);
  // Register stages before the output register; the output register is the last stage.
  localparam int PD   = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int LAST = PD - 1;

  localparam logic [OPW-1:0] OP_MULT_L  = OPW'(0);
  localparam logic [OPW-1:0] OP_MULT_H  = OPW'(1);
  localparam logic [OPW-1:0] OP_MULTU_L = OPW'(2);
  localparam logic [OPW-1:0] OP_MULTU_H = OPW'(3);
  localparam logic [OPW-1:0] OP_DIV_L   = OPW'(4);
  localparam logic [OPW-1:0] OP_DIV_H   = OPW'(5);
  localparam logic [OPW-1:0] OP_DIVU_L  = OPW'(6);
  localparam logic [OPW-1:0] OP_DIVU_H  = OPW'(7);
  localparam logic [OPW-1:0] OP_SYSCALL = OPW'(8);

  localparam logic [5:0] FL_LO  = 6'b011100;
  localparam logic [5:0] FL_HI  = 6'b010100;
  localparam logic [5:0] FL_SYS = 6'b000110;
  localparam logic [5:0] FL_DZ  = 6'b000010;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DIV, S_DONE} state_e;

  state_e                state_q;
  logic                  ready_q, valid_q;
  logic [DATA_W-1:0]     result_q;
  logic [5:0]            flags_q;
  logic [TAG_W-1:0]      tag_q;

  // Multiplier pipe
  logic [PD-1:0]         pv_q;
  logic [DATA_W-1:0]     pr_q [PD];
  logic [5:0]            pf_q [PD];
  logic [TAG_W-1:0]      pt_q [PD];

  // Divider datapath
  logic [DATA_W-1:0]     dq_q, dr_q, dd_q, a_q;
  logic [CW-1:0]         cnt_q;
  logic                  negq_q, negr_q, dz_q, hi_q;
  logic [TAG_W-1:0]      dtag_q;
`ifdef COMPLEX_ALU_EARLY_OUT_EN
  logic                  pre_q;
  logic [CW-1:0]         lz;
`endif

  logic                  accept, is_div, ent_valid, div_signed, div_hi;
  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     mag_a, mag_b;
  logic [2*DATA_W-1:0]   prod_s, prod_u;
  logic [DATA_W-1:0]     ent_res;
  logic [5:0]            ent_flags;
  logic                  mul_v, pipe_busy;
  logic [DATA_W-1:0]     mul_res;
  logic [5:0]            mul_flags;
  logic [TAG_W-1:0]      mul_tag;
  logic [DATA_W:0]       shifted, trial;
  logic [DATA_W-1:0]     q_nx, r_nx, fin_q, fin_r, q_s, r_s, div_res;
  logic [5:0]            div_flags;
  logic                  div_fin;

`ifdef COMPLEX_ALU_EARLY_OUT_EN
  function automatic logic [CW-1:0] clz(input logic [DATA_W-1:0] v);
    logic [CW-1:0] n;
    logic          seen;
    n    = '0;
    seen = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (!seen) begin
        if (v[DATA_W-1-i]) seen = 1'b1;
        else               n = n + 1'b1;
      end
    end
    return n;
  endfunction
`endif

  // Opcode decode, handshake and the multiplier entry stage
  always_comb begin
    accept     = valid_i && ready_q && !flush_i;
    is_div     = (opcode_i == OP_DIV_L) || (opcode_i == OP_DIV_H) ||
                 (opcode_i == OP_DIVU_L) || (opcode_i == OP_DIVU_H);
    div_signed = (opcode_i == OP_DIV_L) || (opcode_i == OP_DIV_H);
    div_hi     = (opcode_i == OP_DIV_H) || (opcode_i == OP_DIVU_H);
    ent_valid  = accept && !is_div;
    a_neg      = div_signed && data1_i[DATA_W-1];
    b_neg      = div_signed && data2_i[DATA_W-1];
    mag_a      = a_neg ? -data1_i : data1_i;
    mag_b      = b_neg ? -data2_i : data2_i;
    prod_s     = {{DATA_W{data1_i[DATA_W-1]}}, data1_i} * {{DATA_W{data2_i[DATA_W-1]}}, data2_i};
    prod_u     = {{DATA_W{1'b0}}, data1_i} * {{DATA_W{1'b0}}, data2_i};
    ent_res    = '0;
    ent_flags  = '0;
    case (opcode_i)
      OP_MULT_L:  begin ent_res = prod_s[DATA_W-1:0];        ent_flags = FL_LO;  end
      OP_MULT_H:  begin ent_res = prod_s[2*DATA_W-1:DATA_W]; ent_flags = FL_HI;  end
      OP_MULTU_L: begin ent_res = prod_u[DATA_W-1:0];        ent_flags = FL_LO;  end
      OP_MULTU_H: begin ent_res = prod_u[2*DATA_W-1:DATA_W]; ent_flags = FL_HI;  end
      OP_SYSCALL: begin ent_res = '0;                        ent_flags = FL_SYS; end
      default:    begin ent_res = '0;                        ent_flags = '0;     end
    endcase
  end

  // Tail of the multiplier pipe feeding the output register
  always_comb begin
    if (MUL_STAGES == 1) begin
      mul_v     = ent_valid;
      mul_res   = ent_res;
      mul_flags = ent_flags;
      mul_tag   = tag_i;
      pipe_busy = 1'b0;
    end else begin
      mul_v     = pv_q[LAST];
      mul_res   = pr_q[LAST];
      mul_flags = pf_q[LAST];
      mul_tag   = pt_q[LAST];
      pipe_busy = |pv_q;
    end
  end

  // One restoring-division step plus sign correction of the final step
  always_comb begin
    shifted = {dr_q, dq_q[DATA_W-1]};
    trial   = shifted - {1'b0, dd_q};
    r_nx    = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    q_nx    = {dq_q[DATA_W-2:0], ~trial[DATA_W]};
`ifdef COMPLEX_ALU_EARLY_OUT_EN
    lz      = clz(dq_q);
    div_fin = (state_q == S_DIV) &&
              (pre_q ? (dz_q || (dq_q == '0)) : (cnt_q == CW'(DATA_W - 1)));
    fin_q   = pre_q ? '0 : q_nx;
    fin_r   = pre_q ? '0 : r_nx;
`else
    div_fin = (state_q == S_DIV) && (cnt_q == CW'(DATA_W - 1));
    fin_q   = q_nx;
    fin_r   = r_nx;
`endif
    q_s       = negq_q ? -fin_q : fin_q;
    r_s       = negr_q ? -fin_r : fin_r;
    if (dz_q) div_res = hi_q ? a_q : '1;
    else      div_res = hi_q ? r_s : q_s;
    div_flags = (hi_q ? FL_HI : FL_LO) | (dz_q ? FL_DZ : 6'b000000);
  end

  // Multiplier pipe: results shift one stage per cycle, squash clears all valids
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < PD; i++) begin
        pr_q[i] <= '0;
        pf_q[i] <= '0;
        pt_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= ent_valid;
      pr_q[0] <= ent_res;
      pf_q[0] <= ent_flags;
      pt_q[0] <= tag_i;
      for (int unsigned i = 1; i < PD; i++) begin
        pv_q[i] <= pv_q[i-1] && !flush_i;
        pr_q[i] <= pr_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
    end
  end

  // Divide FSM, divider registers and the registered result port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      tag_q    <= '0;
      dq_q     <= '0;
      dr_q     <= '0;
      dd_q     <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 1'b0;
      dtag_q   <= '0;
`ifdef COMPLEX_ALU_EARLY_OUT_EN
      pre_q    <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // ready_o is low outside IDLE, so div_fin and mul_v are never both set
      if (div_fin) begin
        valid_q  <= 1'b1;
        result_q <= div_res;
        flags_q  <= div_flags;
        tag_q    <= dtag_q;
      end else if (mul_v) begin
        valid_q  <= 1'b1;
        result_q <= mul_res;
        flags_q  <= mul_flags;
        tag_q    <= mul_tag;
      end
      case (state_q)
        S_IDLE: begin
          if (accept && is_div) begin
            dq_q    <= mag_a;
            dr_q    <= '0;
            dd_q    <= mag_b;
            a_q     <= data1_i;
            cnt_q   <= '0;
            negq_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
            dz_q    <= (data2_i == '0);
            hi_q    <= div_hi;
            dtag_q  <= tag_i;
            ready_q <= 1'b0;
`ifdef COMPLEX_ALU_EARLY_OUT_EN
            pre_q   <= 1'b1;
`endif
            state_q <= pipe_busy ? S_DRAIN : S_DIV;
          end
        end
        S_DRAIN: begin
          if (!pipe_busy) state_q <= S_DIV;
        end
        S_DIV: begin
`ifdef COMPLEX_ALU_EARLY_OUT_EN
          // First DIV cycle pre-shifts the dividend past its leading zeros
          if (pre_q) begin
            pre_q <= 1'b0;
            dq_q  <= dq_q << lz;
            cnt_q <= lz;
          end else begin
            dq_q  <= q_nx;
            dr_q  <= r_nx;
            cnt_q <= cnt_q + 1'b1;
          end
`else
          dq_q  <= q_nx;
          dr_q  <= r_nx;
          cnt_q <= cnt_q + 1'b1;
`endif
          if (div_fin) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o  = ready_q;
    valid_o  = valid_q;
    result_o = result_q;
    flags_o  = flags_q;
    tag_o    = tag_q;
  end

endmodule

// File: tb/tb_complex_alu_mc.sv
// tb_complex_alu_mc: directed and randomized stimulus for complex_alu_mc,
// checked cycle by cycle against a scoreboard of expected results.
module tb_complex_alu_mc;

  localparam int W  = 32;
  localparam int MS = 3;
  localparam int TW = 7;

  localparam logic [3:0] OP_MULT_L  = 4'd0;
  localparam logic [3:0] OP_MULT_H  = 4'd1;
  localparam logic [3:0] OP_MULTU_L = 4'd2;
  localparam logic [3:0] OP_MULTU_H = 4'd3;
  localparam logic [3:0] OP_DIV_L   = 4'd4;
  localparam logic [3:0] OP_DIV_H   = 4'd5;
  localparam logic [3:0] OP_DIVU_L  = 4'd6;
  localparam logic [3:0] OP_DIVU_H  = 4'd7;
  localparam logic [3:0] OP_SYSCALL = 4'd8;

  logic          clk = 1'b0;
  logic          reset_n, valid_i, ready_o, flush_i, valid_o;
  logic [3:0]    opcode_i;
  logic [W-1:0]  data1_i, data2_i, result_o;
  logic [TW-1:0] tag_i, tag_o;
  logic [5:0]    flags_o;

  complex_alu_mc #(.DATA_W(W), .MUL_STAGES(MS), .TAG_W(TW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .opcode_i (opcode_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .flags_o  (flags_o),
    .tag_o    (tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            t;
    logic [W-1:0]  res;
    logic [5:0]    fl;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sbq[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc, busy_until, last_mul_out;
  logic [W-1:0]  hold_res;
  logic [5:0]    hold_fl;
  logic [TW-1:0] hold_tag;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit is_div_op(input logic [3:0] op);
    return (op == OP_DIV_L) || (op == OP_DIV_H) || (op == OP_DIVU_L) || (op == OP_DIVU_H);
  endfunction

  // Reference arithmetic straight from the operation definitions
  task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [5:0] f);
    int           sa, sb, qi, ri;
    longint       sp;
    logic [63:0]  spv, upv;
    logic [W-1:0] q, rm;
    sa  = a;
    sb  = b;
    sp  = longint'(sa) * longint'(sb);
    spv = sp;
    upv = {32'b0, a} * {32'b0, b};
    q   = '0;
    rm  = '0;
    if (b == 0) begin
      q  = '1;
      rm = a;
    end else if (op == OP_DIV_L || op == OP_DIV_H) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q  = a;
        rm = '0;
      end else begin
        qi = sa / sb;
        ri = sa % sb;
        q  = qi;
        rm = ri;
      end
    end else begin
      q  = a / b;
      rm = a % b;
    end
    case (op)
      OP_MULT_L:  begin r = spv[31:0];  f = 6'b011100; end
      OP_MULT_H:  begin r = spv[63:32]; f = 6'b010100; end
      OP_MULTU_L: begin r = upv[31:0];  f = 6'b011100; end
      OP_MULTU_H: begin r = upv[63:32]; f = 6'b010100; end
      OP_DIV_L, OP_DIVU_L: begin r = q;  f = 6'b011100 | ((b == 0) ? 6'b000010 : 6'b0); end
      OP_DIV_H, OP_DIVU_H: begin r = rm; f = 6'b010100 | ((b == 0) ? 6'b000010 : 6'b0); end
      OP_SYSCALL: begin r = '0; f = 6'b000110; end
      default:    begin r = '0; f = 6'b000000; end
    endcase
  endtask

  // Timing model: MUL results MS cycles after acceptance; a divide waits for
  // outstanding MUL results to leave the pipe, then takes W+1 cycles.
  task automatic model_accept(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [TW-1:0] tag);
    exp_t e;
    int   start;
    ref_op(op, a, b, e.res, e.fl);
    e.tag = tag;
    if (is_div_op(op)) begin
      if (last_mul_out <= cyc) start = cyc;
      else                     start = (cyc + 1 > last_mul_out) ? cyc + 1 : last_mul_out;
      e.t        = start + W + 1;
      busy_until = e.t;
    end else begin
      e.t          = cyc + MS;
      last_mul_out = e.t;
    end
    sbq.push_back(e);
  endtask

  // Everything due after the squash cycle is discarded
  task automatic model_flush();
    while (sbq.size() > 0 && sbq[sbq.size()-1].t > cyc) void'(sbq.pop_back());
    if (busy_until > cyc)   busy_until = cyc;
    if (last_mul_out > cyc) last_mul_out = cyc;
  endtask

  task automatic check_outputs();
    exp_t e;
    logic exp_v;
    exp_v = (sbq.size() > 0) && (sbq[0].t == cyc);
    check_eq("valid_o", valid_o, exp_v);
    if (exp_v) begin
      e = sbq.pop_front();
      check_eq("result_o", result_o, e.res);
      check_eq("flags_o", flags_o, e.fl);
      check_eq("tag_o", tag_o, e.tag);
      hold_res = e.res;
      hold_fl  = e.fl;
      hold_tag = e.tag;
    end else begin
      check_eq("result_hold", result_o, hold_res);
      check_eq("flags_hold", flags_o, hold_fl);
      check_eq("tag_hold", tag_o, hold_tag);
    end
  endtask

  // One clock cycle: drive inputs, check on the falling edge, advance the model
  task automatic cycle_step(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [TW-1:0] t, input logic fl,
                            output logic acc);
    logic exp_rdy;
    valid_i  = v;
    opcode_i = op;
    data1_i  = a;
    data2_i  = b;
    tag_i    = t;
    flush_i  = fl;
    @(negedge clk);
    check_outputs();
    exp_rdy = (cyc > busy_until);
    check_eq("ready_o", ready_o, exp_rdy);
    acc = v && exp_rdy && !fl;
    if (acc) model_accept(op, a, b, t);
    if (fl)  model_flush();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) cycle_step(1'b0, 4'd0, '0, '0, '0, 1'b0, acc);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) cycle_step(1'b1, op, a, b, t, 1'b0, acc);
    check_eq("issue_accepted", acc, 1'b1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic reset_mid_divide();
    issue(OP_DIV_L, 32'd1000, 32'd7, 7'd99);
    idle(10);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_valid_o", valid_o, 1'b0);
    check_eq("rst_result_o", result_o, '0);
    check_eq("rst_flags_o", flags_o, '0);
    check_eq("rst_tag_o", tag_o, '0);
    check_eq("rst_ready_o", ready_o, 1'b1);
    sbq.delete();
    hold_res = '0;
    hold_fl  = '0;
    hold_tag = '0;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    busy_until   = cyc - 1;
    last_mul_out = cyc;
    idle(40);
  endtask

  initial begin
    logic acc;
    reset_n  = 1'b0;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    opcode_i = '0;
    data1_i  = '0;
    data2_i  = '0;
    tag_i    = '0;
    hold_res = '0;
    hold_fl  = '0;
    hold_tag = '0;
    cyc          = 0;
    busy_until   = -1;
    last_mul_out = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_valid_o", valid_o, 1'b0);
    check_eq("reset_result_o", result_o, '0);
    check_eq("reset_flags_o", flags_o, '0);
    check_eq("reset_tag_o", tag_o, '0);
    check_eq("reset_ready_o", ready_o, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Multiplies, single and back to back
    issue(OP_MULT_L, 32'hFFFF_FFFE, 32'h0000_0003, 7'd5);
    idle(4);
    issue(OP_MULTU_H, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd6);
    idle(4);
    issue(OP_MULT_L, 32'h1234_5678, 32'h9ABC_DEF0, 7'd10);
    issue(OP_MULT_H, 32'h8000_0000, 32'h8000_0000, 7'd11);
    issue(OP_SYSCALL, 32'h1, 32'h2, 7'd12);
    issue(4'd13, 32'h1, 32'h2, 7'd13);
    idle(5);

    // Divides with an empty pipe, signed corners and divide-by-zero
    issue(OP_DIV_L, 32'hFFFF_FFF9, 32'd2, 7'd20);
    issue(OP_DIV_H, 32'hFFFF_FFF9, 32'd2, 7'd21);
    issue(OP_DIV_L, 32'h8000_0000, 32'hFFFF_FFFF, 7'd22);
    issue(OP_DIVU_L, 32'd10, 32'd0, 7'd23);
    issue(OP_DIVU_H, 32'd10, 32'd0, 7'd24);
    issue(OP_DIV_H, 32'hFFFF_FFF6, 32'd0, 7'd25);
    idle(40);

    // Divide behind a multiply: drain first
    issue(OP_MULT_L, 32'd9, 32'd9, 7'd30);
    issue(OP_DIVU_L, 32'd100, 32'd9, 7'd31);
    idle(45);

    // Squash mid-divide, with an op presented in the squash cycle
    issue(OP_MULT_H, 32'd3, 32'd4, 7'd40);
    issue(OP_DIV_L, 32'd500, 32'd3, 7'd41);
    idle(12);
    cycle_step(1'b1, OP_MULT_L, 32'd2, 32'd2, 7'd42, 1'b1, acc);
    idle(3);
    issue(OP_MULT_L, 32'd5, 32'd6, 7'd43);
    idle(2);
    cycle_step(1'b1, OP_MULT_L, 32'd7, 32'd7, 7'd44, 1'b1, acc);
    idle(5);

    // Randomized traffic with occasional squashes
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (is_div_op(op) && $urandom_range(0, 2) != 0) op = OP_MULT_L;
      cycle_step($urandom_range(0, 3) != 0, op, pick_operand(), pick_operand(),
                 TW'($urandom), $urandom_range(0, 29) == 0, acc);
    end
    idle(45);

    reset_mid_divide();

    for (int k = 0; k < 200 && sbq.size() > 0; k++) idle(1);
    check_eq("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/complex_alu_mc.md
Name: complex_alu_mc

Overview:
- Multi-cycle, parametrised successor to the single-cycle complex execution unit.
- Multiplies through a MUL_STAGES-deep pipeline and divides with an iterative radix-2 restoring divider.
- Sits in the complex-issue lane of EXEC, behind the register-read stage.
- Accepts one op per cycle via valid/ready, returns the result with a pass-through tag, and supports a squash from branch recovery.

Parameters:
- DATA_W, 32: operand/result width; must be even and >= 8.
- MUL_STAGES, 3: multiplier latency in cycles; must be >= 1.
- TAG_W, 7: width of the pass-through instruction tag.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  op present.
- ready_o  out  1  unit can accept this cycle.
- opcode_i  in  `SIZE_OPCODE_I  operation: MULT_L/H, MULTU_L/H, DIV_L/H, DIVU_L/H, SYSCALL.
- data1_i  in  DATA_W  operand A / dividend.
- data2_i  in  DATA_W  operand B / divisor.
- tag_i  in  TAG_W  instruction tag.
- flush_i  in  1  squash all in-flight ops.
- valid_o  out  1  result valid; single-cycle pulse, no backpressure.
- result_o  out  DATA_W  result.
- flags_o  out  6  execution flags.
- tag_o  out  TAG_W  tag of the result.

Behaviour:
- Reset: valid_o=0, result_o=0, flags_o=0, tag_o=0, FSM=IDLE, all pipe valids cleared.
- Handshake: op accepted when valid_i && ready_o && !flush_i.
- ready_o is a registered function of state only (=1 in IDLE).
- Flag bits: [5] reserved 0, [4] result-writes-register, [3] low-half, [2] executed, [1] exception, [0] mispredict (always 0).
- Flag values: *_L ops = 6'b011100; *_H ops = 6'b010100; SYSCALL = 6'b000110.
- Div-by-zero: adds bit1. Quotient = all ones; remainder = dividend.
- MUL path:
  - Signed ops form the full 2*DATA_W signed product; unsigned ops form the full unsigned product.
  - _L returns bits [DATA_W-1:0]; _H returns [2*DATA_W-1:DATA_W].
  - Accepted in cycle T gives valid_o in T+MUL_STAGES.
  - Fully pipelined: one op per cycle.
- SYSCALL and undefined opcodes take the MUL pipe with result 0. Undefined opcodes give flags 0, but valid_o still pulses so the tag retires.
- DIV path FSM: IDLE -> DRAIN -> DIV -> DONE -> IDLE.
  - IDLE: a DIV op with MUL pipe non-empty is captured and goes to DRAIN; with pipe empty it goes straight to DIV.
  - DRAIN: stays until the MUL pipe is empty.
  - DIV: one quotient bit per cycle on operand magnitudes, DATA_W iterations.
  - DONE: sign correction applied, result driven, valid_o=1, back to IDLE.
  - ready_o=0 in DRAIN/DIV/DONE, so DIV and MUL results never collide.
- Divide latency with an empty pipe: accept T, valid_o at T+DATA_W+1.
- Signed divide rules:
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A), truncating toward zero.
  - MIN / -1: quotient = MIN, remainder = 0, no exception.
- DIV_L/DIVU_L return the quotient; DIV_H/DIVU_H return the remainder.
- flush_i:
  - Next cycle: all MUL pipe valids = 0, FSM = IDLE, valid_o = 0.
  - Any op presented in the flush cycle is dropped.
  - A result that would have been output in the flush cycle itself is still output.
- Asynchronous reset mid-divide: immediate return to reset state; no partial result is emitted.
- result_o/flags_o/tag_o hold their last value when valid_o=0.

Optional Feature:
- COMPLEX_ALU_EARLY_OUT_EN defined:
  - In DIV entry, the divider counts leading zeros of |A| and skips those iterations.
  - Latency = 1 + (DATA_W - lz) + 1 cycles.
  - A = 0 finishes in 2 cycles.
  - Divide-by-zero always completes in 2 cycles.
  - Results are identical to the fixed-latency divider.
- Not defined: fixed DATA_W iterations; no leading-zero logic is synthesised.

Test Plan:
- MULT_L 0xFFFFFFFE x 0x00000003, tag 5 -> 3 cycles later: valid_o, result 0xFFFFFFFA, flags 6'b011100, tag 5.
- MULTU_H 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE, flags 6'b010100.
- Back-to-back MULT_L, MULT_H, SYSCALL on consecutive cycles -> three consecutive valid_o pulses, in order, with matching tags.
- DIV_L -7/2 -> -3 (0xFFFFFFFD), then DIV_H -7/2 -> -1:
  - each at T+33, ready_o low throughout;
  - then DIV_L 0x80000000/0xFFFFFFFF -> 0x80000000, no exception.
- DIVU_L 10/0 -> 0xFFFFFFFF, flags 6'b011110; DIVU_H 10/0 -> 10.
- DIV issued 1 cycle after a MULT:
  - MULT result first, then DRAIN, then DIV;
  - flush_i asserted mid-divide -> no valid_o, ready_o=1 next cycle;
  - reset_n pulsed low mid-divide -> outputs 0 immediately.
